// File: rtl/icache_axi_rd_bridge.sv
// Instruction-cache refill responder: turns one cache read request into a single AXI4 read
// burst, gathers the beats into a line buffer and returns the whole line in one cycle.
module icache_axi_rd_bridge #(
    parameter logic [3:0] AXI_ID     = 4'd0,
    parameter int         LINE_BEATS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rd_req,
    input  logic                       rd_type,
    input  logic [31:0]                rd_addr,
    output logic                       rd_rdy,
    output logic                       ret_valid,
    output logic [LINE_BEATS*32-1:0]   ret_data,
    output logic [3:0]                 arid,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [3:0]                 rid,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready
);
    localparam int              BW        = $clog2(LINE_BEATS);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(LINE_BEATS - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_AR   = 4'b0010,
        S_RDAT = 4'b0100,
        S_RET  = 4'b1000
    } state_t;

    state_t                    state, state_nxt;
    logic [31:0]               addr_q;
    logic                      type_q;
    logic [BW-1:0]             beat_cnt;
    logic                      last_written;
    logic [LINE_BEATS*32-1:0]  line_buf;
    logic                      beat_ok;
    logic                      unused_resp;

    assign unused_resp = ^rresp;
    assign beat_ok     = (state == S_RDAT) && rvalid && (rid == AXI_ID);

    // Line buffer doubles as ret_data: it is held after RET until the next request clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            type_q       <= 1'b0;
            beat_cnt     <= '0;
            last_written <= 1'b0;
            line_buf     <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && rd_req) begin
                addr_q       <= rd_addr;
                type_q       <= rd_type;
                beat_cnt     <= '0;
                last_written <= 1'b0;
                line_buf     <= '0;
            end else if (beat_ok) begin
                // Counter parks on the last word; beats beyond a full line are discarded
                if (!last_written)
                    line_buf[{beat_cnt, 5'b0} +: 32] <= rdata;
                if (beat_cnt == LAST_BEAT)
                    last_written <= 1'b1;
                else
                    beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rd_rdy    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        ret_valid = 1'b0;
        case (state)
            S_IDLE: begin
                rd_rdy = 1'b1;
                if (rd_req)
                    state_nxt = S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready)
                    state_nxt = S_RDAT;
            end
            S_RDAT: begin
                rready = 1'b1;
                if (beat_ok && rlast)
                    state_nxt = S_RET;
            end
            S_RET: begin
                ret_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign arid     = AXI_ID;
    assign araddr   = type_q ? {addr_q[31:5], 5'b0} : addr_q;
    assign arlen    = type_q ? 8'(LINE_BEATS - 1) : 8'd0;
    assign arsize   = 3'b010;
    assign arburst  = 2'b01;
    assign ret_data = line_buf;

endmodule
